wb_regfile: RTL and testbench

Writeback-side register file for the 32-bit datapath. It sits directly downstream of the writeback select stage and consumes that stage's 32-bit result together with its 5-bit destination register number. Results are captured into a one-entry pending-write register and committed to a 32 x 32 array one cycle later. The block provides two bypassed combinational read ports and a busy-bit scoreboard that flags read-after-write hazards to the issue logic.

---
 rtl/wb_regfile.sv | 157 +++++++++++++++
 tb/tb_wb_regfile.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/wb_regfile.sv
// ---------------------------------------------------------------------------
// wb_regfile
//   Writeback-side register file for the 32-bit datapath. A writeback result
//   is captured into a one-entry pending-write register and committed to the
//   register array on the following edge. Two combinational read ports bypass
//   both the live writeback and the pending entry. A busy-bit scoreboard flags
//   read-after-write hazards to the issue logic.
//
// Ports
//   clk          in   rising-edge clock
//   rst_n        in   asynchronous active-low reset
//   wb_valid     in   writeback result present this cycle
//   wb_rd        in   [AW-1:0] writeback destination register
//   wb_data      in   [DW-1:0] writeback result
//   issue_valid  in   an instruction with a destination issues this cycle
//   issue_rd     in   [AW-1:0] destination of the issuing instruction
//   rs1, rs2     in   [AW-1:0] read addresses
//   rd1, rd2     out  [DW-1:0] bypassed read data (combinational)
//   hazard       out  a read source awaits a producer with no bypass
// ---------------------------------------------------------------------------
module wb_regfile #(
    parameter int DW = 32,
    parameter int AW = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wb_valid,
    input  logic [AW-1:0] wb_rd,
    input  logic [DW-1:0] wb_data,
    input  logic          issue_valid,
    input  logic [AW-1:0] issue_rd,
    input  logic [AW-1:0] rs1,
    input  logic [AW-1:0] rs2,
    output logic [DW-1:0] rd1,
    output logic [DW-1:0] rd2,
    output logic          hazard
);

    localparam int NREG = 1 << AW;

    // Entry 0 is never written, so it stays at its reset value of zero.
    logic [DW-1:0]   r_regs [0:NREG-1];
    logic            r_pend_v;
    logic [AW-1:0]   r_pend_rd;
    logic [DW-1:0]   r_pend_data;
    // Bit 0 is never set; register 0 can never be busy.
    logic [NREG-1:0] r_busy;

    logic            w_wb_live;
    logic            w_issue_live;
    logic [NREG-1:0] w_set_mask;
    logic [NREG-1:0] w_clr_mask;
    logic            w_rs1_wait;
    logic            w_rs2_wait;

    // Writebacks and issues targeting register 0 have no architectural effect.
    always_comb begin
        w_wb_live    = wb_valid & (wb_rd != {AW{1'b0}});
        w_issue_live = issue_valid & (issue_rd != {AW{1'b0}});
        w_set_mask   = {NREG{1'b0}};
        w_clr_mask   = {NREG{1'b0}};
        if (w_issue_live) begin
            w_set_mask[issue_rd] = 1'b1;
        end else begin
            w_set_mask = {NREG{1'b0}};
        end
        if (w_wb_live) begin
            w_clr_mask[wb_rd] = 1'b1;
        end else begin
            w_clr_mask = {NREG{1'b0}};
        end
    end

    // Pending-write capture: a fresh result replaces the entry every cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pend_v    <= 1'b0;
            r_pend_rd   <= {AW{1'b0}};
            r_pend_data <= {DW{1'b0}};
        end else begin
            r_pend_v <= w_wb_live;
            if (w_wb_live) begin
                r_pend_rd   <= wb_rd;
                r_pend_data <= wb_data;
            end else begin
                r_pend_rd   <= r_pend_rd;
                r_pend_data <= r_pend_data;
            end
        end
    end

    // Array commit of the pending entry, on the same edge as the next capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                r_regs[i] <= {DW{1'b0}};
            end
        end else begin
            if (r_pend_v) begin
                r_regs[r_pend_rd] <= r_pend_data;
            end else begin
                r_regs[r_pend_rd] <= r_regs[r_pend_rd];
            end
        end
    end

    // Scoreboard: a newer issue to the same register outranks the writeback
    // clear, so the set mask is applied after the clear mask.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy <= {NREG{1'b0}};
        end else begin
            r_busy <= (r_busy & ~w_clr_mask) | w_set_mask;
        end
    end

    // Read port 1: zero register, live writeback, pending entry, then array.
    always_comb begin
        rd1 = {DW{1'b0}};
        if (!rst_n || (rs1 == {AW{1'b0}})) begin
            rd1 = {DW{1'b0}};
        end else if (wb_valid && (wb_rd == rs1)) begin
            rd1 = wb_data;
        end else if (r_pend_v && (r_pend_rd == rs1)) begin
            rd1 = r_pend_data;
        end else begin
            rd1 = r_regs[rs1];
        end
    end

    // Read port 2: same priority as port 1.
    always_comb begin
        rd2 = {DW{1'b0}};
        if (!rst_n || (rs2 == {AW{1'b0}})) begin
            rd2 = {DW{1'b0}};
        end else if (wb_valid && (wb_rd == rs2)) begin
            rd2 = wb_data;
        end else if (r_pend_v && (r_pend_rd == rs2)) begin
            rd2 = r_pend_data;
        end else begin
            rd2 = r_regs[rs2];
        end
    end

    // Hazard: a busy source is only a stall if the live writeback cannot
    // bypass it this cycle.
    always_comb begin
        w_rs1_wait = (rs1 != {AW{1'b0}}) & r_busy[rs1] & ~(wb_valid & (wb_rd == rs1));
        w_rs2_wait = (rs2 != {AW{1'b0}}) & r_busy[rs2] & ~(wb_valid & (wb_rd == rs2));
        if (!rst_n) begin
            hazard = 1'b0;
        end else begin
            hazard = w_rs1_wait | w_rs2_wait;
        end
    end

endmodule

// File: tb/tb_wb_regfile.sv
// ---------------------------------------------------------------------------
// tb_wb_regfile
//   Directed self-checking bench for wb_regfile. Inputs change 1 ns after a
//   rising edge; outputs are compared 1 ns later, well away from the edge.
// ---------------------------------------------------------------------------
module tb_wb_regfile;

    logic        clk;
    logic        rst_n;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        issue_valid;
    logic [4:0]  issue_rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic        hazard;

    int checks = 0;
    int errors = 0;

    wb_regfile #(.DW(32), .AW(5)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .wb_valid    (wb_valid),
        .wb_rd       (wb_rd),
        .wb_data     (wb_data),
        .issue_valid (issue_valid),
        .issue_rd    (issue_rd),
        .rs1         (rs1),
        .rs2         (rs2),
        .rd1         (rd1),
        .rd2         (rd2),
        .hazard      (hazard)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to just after the next rising edge (start of a new cycle).
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Apply one cycle's inputs and let the combinational outputs settle.
    task automatic drive(input logic wv, input logic [4:0] wrd, input logic [31:0] wd,
                         input logic iv, input logic [4:0] ird,
                         input logic [4:0] a1, input logic [4:0] a2);
        wb_valid    = wv;
        wb_rd       = wrd;
        wb_data     = wd;
        issue_valid = iv;
        issue_rd    = ird;
        rs1         = a1;
        rs2         = a2;
        #1;
    endtask

    task automatic test_reset();
        // Power-on reset state.
        checks++; if (rd1 !== 32'h0) begin errors++; $display("FAIL por_rd1 got %h exp %h", rd1, 32'h0); end
        checks++; if (hazard !== 1'b0) begin errors++; $display("FAIL por_hazard got %b exp %b", hazard, 1'b0); end
        next_cycle();
        rst_n = 1'b1;
        // Mid-run: write r3 and issue r4, then reset while r3 is pending.
        next_cycle();
        drive(1'b1, 5'd3, 32'h0000_1234, 1'b1, 5'd4, 5'd0, 5'd0);
        next_cycle();
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd3, 5'd4);
        checks++; if (rd1 !== 32'h0000_1234) begin errors++; $display("FAIL rst_prep_pend got %h exp %h", rd1, 32'h0000_1234); end
        checks++; if (hazard !== 1'b1) begin errors++; $display("FAIL rst_prep_haz got %b exp %b", hazard, 1'b1); end
        rst_n = 1'b0;
        #1;
        checks++; if (rd1 !== 32'h0) begin errors++; $display("FAIL rst_rd1 got %h exp %h", rd1, 32'h0); end
        checks++; if (rd2 !== 32'h0) begin errors++; $display("FAIL rst_rd2 got %h exp %h", rd2, 32'h0); end
        checks++; if (hazard !== 1'b0) begin errors++; $display("FAIL rst_hazard got %b exp %b", hazard, 1'b0); end
        next_cycle();
        rst_n = 1'b1;
        next_cycle();
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd5, 5'd3);
        checks++; if (rd1 !== 32'h0) begin errors++; $display("FAIL rst_r5 got %h exp %h", rd1, 32'h0); end
        checks++; if (rd2 !== 32'h0) begin errors++; $display("FAIL rst_lost_pend got %h exp %h", rd2, 32'h0); end
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd4);
        checks++; if (hazard !== 1'b0) begin errors++; $display("FAIL rst_busy_clr got %b exp %b", hazard, 1'b0); end
    endtask

    task automatic test_read_latency();
        next_cycle();
        drive(1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0, 5'd0, 5'd5, 5'd0);
        checks++; if (rd1 !== 32'hDEAD_BEEF) begin errors++; $display("FAIL lat_c0_bypass got %h exp %h", rd1, 32'hDEAD_BEEF); end
        for (int c = 1; c <= 3; c++) begin
            next_cycle();
            drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd5, 5'd0);
            checks++; if (rd1 !== 32'hDEAD_BEEF) begin errors++; $display("FAIL lat_c%0d got %h exp %h", c, rd1, 32'hDEAD_BEEF); end
        end
    endtask

    task automatic test_r0_write();
        // Pending entry holds r6 and r10 becomes busy before the r0 write.
        next_cycle();
        drive(1'b1, 5'd6, 32'h0000_0066, 1'b1, 5'd10, 5'd0, 5'd0);
        next_cycle();
        drive(1'b1, 5'd0, 32'hFFFF_FFFF, 1'b0, 5'd0, 5'd0, 5'd0);
        checks++; if (rd1 !== 32'h0) begin errors++; $display("FAIL r0_rd1 got %h exp %h", rd1, 32'h0); end
        checks++; if (rd2 !== 32'h0) begin errors++; $display("FAIL r0_rd2 got %h exp %h", rd2, 32'h0); end
        next_cycle();
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd10, 5'd6);
        checks++; if (hazard !== 1'b1) begin errors++; $display("FAIL r0_busy_kept got %b exp %b", hazard, 1'b1); end
        checks++; if (rd2 !== 32'h0000_0066) begin errors++; $display("FAIL r0_r6_kept got %h exp %h", rd2, 32'h0000_0066); end
        next_cycle();
        drive(1'b1, 5'd10, 32'h0000_0010, 1'b0, 5'd0, 5'd10, 5'd0);
        checks++; if (hazard !== 1'b0) begin errors++; $display("FAIL r10_wb_haz got %b exp %b", hazard, 1'b0); end
        checks++; if (rd1 !== 32'h0000_0010) begin errors++; $display("FAIL r10_wb_data got %h exp %h", rd1, 32'h0000_0010); end
    endtask

    task automatic test_back_to_back();
        next_cycle();
        drive(1'b1, 5'd7, 32'h1, 1'b0, 5'd0, 5'd7, 5'd0);
        checks++; if (rd1 !== 32'h1) begin errors++; $display("FAIL b2b_c0 got %h exp %h", rd1, 32'h1); end
        next_cycle();
        drive(1'b1, 5'd7, 32'h2, 1'b0, 5'd0, 5'd7, 5'd0);
        checks++; if (rd1 !== 32'h2) begin errors++; $display("FAIL b2b_c1 got %h exp %h", rd1, 32'h2); end
        next_cycle();
        drive(1'b1, 5'd8, 32'h3, 1'b0, 5'd0, 5'd7, 5'd8);
        checks++; if (rd1 !== 32'h2) begin errors++; $display("FAIL b2b_c2_r7 got %h exp %h", rd1, 32'h2); end
        checks++; if (rd2 !== 32'h3) begin errors++; $display("FAIL b2b_c2_r8 got %h exp %h", rd2, 32'h3); end
        next_cycle();
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd7, 5'd8);
        checks++; if (rd1 !== 32'h2) begin errors++; $display("FAIL b2b_c3_r7 got %h exp %h", rd1, 32'h2); end
        next_cycle();
        next_cycle();
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd7, 5'd8);
        checks++; if (rd1 !== 32'h2) begin errors++; $display("FAIL b2b_c5_r7 got %h exp %h", rd1, 32'h2); end
        checks++; if (rd2 !== 32'h3) begin errors++; $display("FAIL b2b_c5_r8 got %h exp %h", rd2, 32'h3); end
    endtask

    task automatic test_hazard();
        next_cycle();
        drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 5'd0, 5'd9);
        checks++; if (hazard !== 1'b0) begin errors++; $display("FAIL haz_c0 got %b exp %b", hazard, 1'b0); end
        for (int c = 1; c <= 3; c++) begin
            next_cycle();
            drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd9);
            checks++; if (hazard !== 1'b1) begin errors++; $display("FAIL haz_c%0d got %b exp %b", c, hazard, 1'b1); end
        end
        next_cycle();
        drive(1'b1, 5'd9, 32'h0000_0055, 1'b0, 5'd0, 5'd0, 5'd9);
        checks++; if (hazard !== 1'b0) begin errors++; $display("FAIL haz_c4 got %b exp %b", hazard, 1'b0); end
        checks++; if (rd2 !== 32'h0000_0055) begin errors++; $display("FAIL haz_c4_rd2 got %h exp %h", rd2, 32'h0000_0055); end
        next_cycle();
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd9);
        checks++; if (hazard !== 1'b0) begin errors++; $display("FAIL haz_c5 got %b exp %b", hazard, 1'b0); end
        checks++; if (rd2 !== 32'h0000_0055) begin errors++; $display("FAIL haz_c5_rd2 got %h exp %h", rd2, 32'h0000_0055); end
    endtask

    task automatic test_set_wins();
        next_cycle();
        drive(1'b1, 5'd12, 32'h0000_000A, 1'b1, 5'd12, 5'd12, 5'd0);
        checks++; if (hazard !== 1'b0) begin errors++; $display("FAIL sw_c0_haz got %b exp %b", hazard, 1'b0); end
        next_cycle();
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd12, 5'd0);
        checks++; if (hazard !== 1'b1) begin errors++; $display("FAIL sw_c1_haz got %b exp %b", hazard, 1'b1); end
        checks++; if (rd1 !== 32'h0000_000A) begin errors++; $display("FAIL sw_c1_rd1 got %h exp %h", rd1, 32'h0000_000A); end
        next_cycle();
        drive(1'b1, 5'd12, 32'h0000_000B, 1'b0, 5'd0, 5'd0, 5'd12);
        checks++; if (hazard !== 1'b0) begin errors++; $display("FAIL sw_c2_haz got %b exp %b", hazard, 1'b0); end
        next_cycle();
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd12);
        checks++; if (hazard !== 1'b0) begin errors++; $display("FAIL sw_c3_haz got %b exp %b", hazard, 1'b0); end
        checks++; if (rd2 !== 32'h0000_000B) begin errors++; $display("FAIL sw_c3_rd2 got %h exp %h", rd2, 32'h0000_000B); end
    endtask

    initial begin
        rst_n = 1'b0;
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd5, 5'd0);
        test_reset();
        test_read_latency();
        test_r0_write();
        test_back_to_back();
        test_hazard();
        test_set_wins();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
